// File: rtl/mult_div_unit.sv
// mult_div_unit: sequential signed multiply/divide, one iteration per cycle on operand magnitudes.
module mult_div_unit #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo,
  output logic             busy,
  output logic             done,
  output logic             zero_exception
);
  typedef enum logic [1:0] {IDLE, MULT, DIV, FIN} state_t;
  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);
  state_t state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] acc_q, acc_d, q_q, q_d, m_q, m_d, hi_q, hi_d, lo_q, lo_d;
  logic neg_q, neg_d, rneg_q, rneg_d, div_q, div_d, done_q, done_d, zx_q, zx_d;
  logic [WIDTH-1:0] a_mag, b_mag, quo, rem, diff;
  logic [WIDTH:0] addend, rsh;
  logic [2*WIDTH-1:0] prod;
  logic ge;
  // acc/q form one shift register: product {acc,q} for MULT, remainder/quotient for DIV
  always_comb begin
    a_mag = a[WIDTH-1] ? -a : a;
    b_mag = b[WIDTH-1] ? -b : b;
    addend = q_q[0] ? {1'b0, acc_q} + {1'b0, m_q} : {1'b0, acc_q};
    rsh = {acc_q, q_q[WIDTH-1]};
    ge = rsh >= {1'b0, m_q};
    diff = rsh[WIDTH-1:0] - m_q;
    prod = neg_q ? -{acc_q, q_q} : {acc_q, q_q};
    quo = neg_q ? -q_q : q_q;
    rem = rneg_q ? -acc_q : acc_q;
    state_d = state_q;
    cnt_d = cnt_q;
    acc_d = acc_q;
    q_d = q_q;
    m_d = m_q;
    neg_d = neg_q;
    rneg_d = rneg_q;
    div_d = div_q;
    hi_d = hi_q;
    lo_d = lo_q;
    done_d = 1'b0;
    zx_d = 1'b0;
    case (state_q)
      IDLE: if (start) begin
        if (!op || b != '0) begin
          state_d = op ? DIV : MULT;
          cnt_d = '0;
          acc_d = '0;
          q_d = op ? a_mag : b_mag;
          m_d = op ? b_mag : a_mag;
          neg_d = a[WIDTH-1] ^ b[WIDTH-1];
          rneg_d = a[WIDTH-1];
          div_d = op;
        end else zx_d = 1'b1;
      end
      MULT: begin
        acc_d = addend[WIDTH:1];
        q_d = {addend[0], q_q[WIDTH-1:1]};
        cnt_d = cnt_q + 1'b1;
        state_d = (cnt_q == LAST) ? FIN : MULT;
      end
      DIV: begin
        acc_d = ge ? diff : rsh[WIDTH-1:0];
        q_d = {q_q[WIDTH-2:0], ge};
        cnt_d = cnt_q + 1'b1;
        state_d = (cnt_q == LAST) ? FIN : DIV;
      end
      FIN: begin
        hi_d = div_q ? rem : prod[2*WIDTH-1:WIDTH];
        lo_d = div_q ? quo : prod[WIDTH-1:0];
        done_d = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= IDLE;
      cnt_q <= '0;
      acc_q <= '0;
      q_q <= '0;
      m_q <= '0;
      neg_q <= 1'b0;
      rneg_q <= 1'b0;
      div_q <= 1'b0;
      hi_q <= '0;
      lo_q <= '0;
      done_q <= 1'b0;
      zx_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q <= cnt_d;
      acc_q <= acc_d;
      q_q <= q_d;
      m_q <= m_d;
      neg_q <= neg_d;
      rneg_q <= rneg_d;
      div_q <= div_d;
      hi_q <= hi_d;
      lo_q <= lo_d;
      done_q <= done_d;
      zx_q <= zx_d;
    end
  end
  assign hi = hi_q;
  assign lo = lo_q;
  assign busy = state_q != IDLE;
  assign done = done_q;
  assign zero_exception = zx_q;
endmodule

// File: tb/tb_mult_div_unit.sv
// tb_mult_div_unit: directed plus random checks of mult_div_unit against a plain-arithmetic model.
module tb_mult_div_unit;
  localparam int W = 32;
  logic clk = 1'b0, reset = 1'b0, start = 1'b0, op = 1'b0;
  logic [W-1:0] a = '0, b = '0;
  logic [W-1:0] hi, lo;
  logic busy, done, zero_exception;
  logic [W-1:0] exp_hi = '0, exp_lo = '0;
  int checks = 0, errors = 0;
  bit saw_done;
  always #5 clk = ~clk;
  mult_div_unit #(.WIDTH(W)) dut (
    .clk(clk), .reset(reset), .start(start), .op(op), .a(a), .b(b),
    .hi(hi), .lo(lo), .busy(busy), .done(done), .zero_exception(zero_exception)
  );
  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask
  function automatic logic [63:0] model(input logic o, input logic [W-1:0] x, input logic [W-1:0] y);
    longint sx, sy;
    logic [63:0] q, r;
    sx = longint'($signed(x));
    sy = longint'($signed(y));
    if (!o) return 64'(sx * sy);
    q = 64'(sx / sy);
    r = 64'(sx % sy);
    return {r[31:0], q[31:0]};
  endfunction
  // Caller is at a negedge; start is raised immediately so back-to-back calls start in the done cycle.
  task automatic run(input logic o, input logic [W-1:0] x, input logic [W-1:0] y, input bit hold);
    logic [63:0] e;
    int lat;
    e = model(o, x, y);
    lat = 0;
    start = 1'b1; op = o; a = x; b = y;
    @(negedge clk);
    chk("done_pulse_drop", done, 0);
    while (!done && lat < 60) begin
      chk("busy_during_op", busy, 1);
      start = hold; op = 1'($urandom); a = $urandom; b = $urandom;
      @(negedge clk);
      lat++;
    end
    start = 1'b0;
    chk("latency", 64'(lat), 64'(W + 1));
    chk("busy_in_done", busy, 0);
    chk("done", done, 1);
    chk("zx_in_done", zero_exception, 0);
    chk("hi", hi, e[63:32]);
    chk("lo", lo, e[31:0]);
    exp_hi = e[63:32];
    exp_lo = e[31:0];
  endtask
  task automatic div0(input logic [W-1:0] x);
    start = 1'b1; op = 1'b1; a = x; b = '0;
    @(negedge clk);
    start = 1'b0;
    chk("zx_pulse", zero_exception, 1);
    chk("zx_busy", busy, 0);
    chk("zx_done", done, 0);
    chk("zx_hi", hi, exp_hi);
    chk("zx_lo", lo, exp_lo);
    @(negedge clk);
    chk("zx_one_cycle", zero_exception, 0);
    chk("zx_busy2", busy, 0);
    chk("zx_done2", done, 0);
    chk("zx_hi2", hi, exp_hi);
    chk("zx_lo2", lo, exp_lo);
  endtask
  task automatic idle(input int n);
    start = 1'b0;
    repeat (n) @(negedge clk);
  endtask
  function automatic logic [W-1:0] pick();
    case ($urandom_range(0, 5))
      0: return 32'h8000_0000;
      1: return 32'hFFFF_FFFF;
      2: return 32'(($urandom_range(0, 20)));
      3: return 32'h7FFF_FFFF;
      default: return $urandom;
    endcase
  endfunction
  initial begin
    logic o;
    logic [W-1:0] x, y;
    repeat (2) @(negedge clk);
    chk("rst_hi", hi, 0);
    chk("rst_lo", lo, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_zx", zero_exception, 0);
    reset = 1'b1;
    idle(1);
    run(1'b0, 32'd7, -32'sd3, 1'b0);
    chk("mult_7x-3_hi", hi, 32'hFFFF_FFFF);
    chk("mult_7x-3_lo", lo, 32'hFFFF_FFEB);
    idle(2);
    run(1'b0, 32'h8000_0000, 32'h8000_0000, 1'b0);
    chk("mult_minsq_hi", hi, 32'h4000_0000);
    chk("mult_minsq_lo", lo, 32'h0);
    idle(1);
    run(1'b1, -32'sd7, 32'd2, 1'b0);
    chk("div_-7/2_lo", lo, 32'hFFFF_FFFD);
    chk("div_-7/2_hi", hi, 32'hFFFF_FFFF);
    run(1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0);
    chk("div_min/-1_lo", lo, 32'h8000_0000);
    chk("div_min/-1_hi", hi, 32'h0);
    div0(32'd100);
    start = 1'b1; op = 1'b0; a = $urandom; b = $urandom;
    @(negedge clk);
    start = 1'b0;
    repeat (9) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    chk("midrst_hi", hi, 0);
    chk("midrst_lo", lo, 0);
    chk("midrst_busy", busy, 0);
    chk("midrst_done", done, 0);
    exp_hi = '0;
    exp_lo = '0;
    start = 1'b1; op = 1'b0; a = 32'd5; b = 32'd5;
    @(negedge clk);
    chk("rst_over_start", busy, 0);
    reset = 1'b1;
    start = 1'b0;
    saw_done = 1'b0;
    repeat (40) begin
      @(negedge clk);
      saw_done |= done;
    end
    chk("no_done_after_rst", saw_done, 0);
    run(1'b1, 32'd100, 32'd7, 1'b0);
    chk("div_100/7_lo", lo, 32'd14);
    chk("div_100/7_hi", hi, 32'd2);
    idle(1);
    run(1'b0, $urandom, $urandom, 1'b1);
    run(1'b0, $urandom, $urandom, 1'b0);
    for (int i = 0; i < 24; i++) begin
      o = 1'($urandom);
      x = pick();
      y = ($urandom_range(0, 5) == 0) ? '0 : pick();
      if (o && y == '0) div0(x);
      else run(o, x, y, 1'($urandom));
      idle($urandom_range(0, 2));
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
